// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the write engine and the VGA scan-out.
// Geometry, widths, the drawing-command opcodes, the colour type and the
// shift-add constant multiply used to turn a line number into a row base.
package fb_pkg;

    localparam int FB_WIDTH  = 214;
    localparam int FB_HEIGHT = 160;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 16;
    localparam int COLOR_W   = 3;
    localparam int COORD_W   = 8;

    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(FB_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(FB_HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  WIDTH_K = ADDR_W'(FB_WIDTH);

    typedef enum logic [1:0] {
        FB_NOP       = 2'd0,
        FB_PLOT      = 2'd1,
        FB_FILL_RECT = 2'd2,
        FB_CLEAR     = 2'd3
    } fb_op_t;

    typedef logic [COLOR_W-1:0] fb_color_t;

    // y * FB_WIDTH built only from shifts and adds of the set bits of the
    // constant, so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] mul_fb_width(input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] acc;
        logic [ADDR_W-1:0] yw;
        acc = '0;
        yw  = ADDR_W'(y);
        for (int i = 0; i < ADDR_W; i++) begin
            if (WIDTH_K[i]) begin
                acc = acc + (yw << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_raster_cnt.sv
// Raster walker for one drawing command: x/y counters, the row-base
// accumulator and last-pixel detect. The nxt_* outputs are the pixel the
// owner will present after the coming edge, so the owner can register the
// write address from them with a single adder.
module fb_raster_cnt
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_async,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] ld_xs,
    input  logic [COORD_W-1:0] ld_ys,
    input  logic [COORD_W-1:0] ld_xe,
    input  logic [COORD_W-1:0] ld_ye,
    input  logic [ADDR_W-1:0]  ld_row_base,
    output logic [COORD_W-1:0] nxt_x,
    output logic [COORD_W-1:0] nxt_y,
    output logic [ADDR_W-1:0]  nxt_row_base,
    output logic               last
);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] xs_r;
    logic [COORD_W-1:0] xe_r;
    logic [COORD_W-1:0] ye_r;
    logic [ADDR_W-1:0]  row_base;

    // The current pixel is the final one of the rectangle.
    assign last = (x == xe_r) && (y == ye_r);

    // Next raster position: load the first corner, or step x with wrap to the next row.
    always_comb begin
        nxt_x        = x;
        nxt_y        = y;
        nxt_row_base = row_base;
        if (load) begin
            nxt_x        = ld_xs;
            nxt_y        = ld_ys;
            nxt_row_base = ld_row_base;
        end else if (step) begin
            if (x == xe_r) begin
                nxt_x        = xs_r;
                nxt_y        = y + 8'd1;
                nxt_row_base = row_base + WIDTH_K;
            end else begin
                nxt_x = x + 8'd1;
            end
        end
    end

    // Counter and bound registers; bounds are captured only when a command loads.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            xs_r     <= '0;
            xe_r     <= '0;
            ye_r     <= '0;
        end else begin
            x        <= nxt_x;
            y        <= nxt_y;
            row_base <= nxt_row_base;
            if (load) begin
                xs_r <= ld_xs;
                xe_r <= ld_xe;
                ye_r <= ld_ye;
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write engine: accepts PLOT / FILL_RECT / CLEAR commands over a
// valid/ready handshake and emits one registered framebuffer write per clock
// in raster order. Optional macro FB_WRITER_CLIP_EN clamps coordinates to the
// screen at accept; without it off-screen pixels still take a cycle but are
// presented with fb_we low.
module fb_writer
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_async,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  fb_color_t          cmd_color,
    output logic               busy,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_waddr,
    output fb_color_t          fb_wdata
);

    typedef enum logic {
        ST_IDLE,
        ST_DRAW
    } state_t;

    state_t             state;
    fb_op_t             op;
    logic               start;
    logic               step;
    logic [COORD_W-1:0] cx0, cx1, cy0, cy1;
    logic [COORD_W-1:0] n_xs, n_xe, n_ys, n_ye;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic [ADDR_W-1:0]  nxt_row_base;
    logic [ADDR_W-1:0]  nxt_addr;
    logic               nxt_on_screen;
    logic               cnt_last;

    assign op    = fb_op_t'(cmd_op);
    assign start = cmd_valid && cmd_ready && (op != FB_NOP);
    assign step  = (state == ST_DRAW) && !cnt_last;
    assign busy  = ~cmd_ready;

`ifdef FB_WRITER_CLIP_EN
    assign cx0 = (cmd_x0 > X_MAX) ? X_MAX : cmd_x0;
    assign cx1 = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
    assign cy0 = (cmd_y0 > Y_MAX) ? Y_MAX : cmd_y0;
    assign cy1 = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
`else
    assign cx0 = cmd_x0;
    assign cx1 = cmd_x1;
    assign cy0 = cmd_y0;
    assign cy1 = cmd_y1;
`endif

    // Normalise the command into an ordered rectangle (xs..xe, ys..ye).
    always_comb begin
        n_xs = (cx0 < cx1) ? cx0 : cx1;
        n_xe = (cx0 < cx1) ? cx1 : cx0;
        n_ys = (cy0 < cy1) ? cy0 : cy1;
        n_ye = (cy0 < cy1) ? cy1 : cy0;
        case (op)
            FB_PLOT: begin
                n_xs = cx0;
                n_xe = cx0;
                n_ys = cy0;
                n_ye = cy0;
            end
            FB_CLEAR: begin
                n_xs = '0;
                n_ys = '0;
                n_xe = X_MAX;
                n_ye = Y_MAX;
            end
            default: begin
            end
        endcase
    end

    fb_raster_cnt u_cnt (
        .clk          (clk),
        .rst_async    (rst_async),
        .load         (start),
        .step         (step),
        .ld_xs        (n_xs),
        .ld_ys        (n_ys),
        .ld_xe        (n_xe),
        .ld_ye        (n_ye),
        .ld_row_base  (mul_fb_width(n_ys)),
        .nxt_x        (nxt_x),
        .nxt_y        (nxt_y),
        .nxt_row_base (nxt_row_base),
        .last         (cnt_last)
    );

    // Off-screen pixels keep their cycle but must never reach the framebuffer.
    assign nxt_addr      = nxt_row_base + ADDR_W'(nxt_x);
    assign nxt_on_screen = (nxt_x <= X_MAX) && (nxt_y <= Y_MAX);

    // Handshake/draw state machine with registered write-port outputs.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            fb_we     <= 1'b0;
            fb_waddr  <= '0;
            fb_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_DRAW;
                        cmd_ready <= 1'b0;
                        fb_we     <= nxt_on_screen;
                        fb_waddr  <= nxt_addr;
                        fb_wdata  <= cmd_color;
                    end
                end
                ST_DRAW: begin
                    if (cnt_last) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        fb_we     <= 1'b0;
                    end else begin
                        fb_we    <= nxt_on_screen;
                        fb_waddr <= nxt_addr;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    fb_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer. A behavioural model turns each command
// into the list of cycles it should present (write enable, address, data)
// using plain rectangle arithmetic; directed and random commands are checked
// cycle by cycle against it.
module tb_fb_writer;
    import fb_pkg::*;

    typedef struct {
        bit we;
        int addr;
        int data;
    } pix_t;

    typedef struct {
        int op;
        int x0;
        int y0;
        int x1;
        int y1;
        int color;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_async = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_x0 = 8'd0;
    logic [7:0]  cmd_y0 = 8'd0;
    logic [7:0]  cmd_x1 = 8'd0;
    logic [7:0]  cmd_y1 = 8'd0;
    logic [2:0]  cmd_color = 3'd0;
    logic        busy;
    logic        fb_we;
    logic [15:0] fb_waddr;
    logic [2:0]  fb_wdata;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];

    fb_writer dut (
        .clk       (clk),
        .rst_async (rst_async),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .fb_we     (fb_we),
        .fb_waddr  (fb_waddr),
        .fb_wdata  (fb_wdata)
    );

    always #5 clk = ~clk;

    // Reference model: every cycle a command should present, in raster order.
    task automatic model_cmd(input int op, input int x0, input int y0,
                             input int x1, input int y1, input int color);
        int   xs, xe, ys, ye;
        pix_t p;
        exp_q.delete();
`ifdef FB_WRITER_CLIP_EN
        if (x0 > FB_WIDTH - 1)  x0 = FB_WIDTH - 1;
        if (x1 > FB_WIDTH - 1)  x1 = FB_WIDTH - 1;
        if (y0 > FB_HEIGHT - 1) y0 = FB_HEIGHT - 1;
        if (y1 > FB_HEIGHT - 1) y1 = FB_HEIGHT - 1;
`endif
        if (op == 0) return;
        xs = (x0 < x1) ? x0 : x1;
        xe = (x0 < x1) ? x1 : x0;
        ys = (y0 < y1) ? y0 : y1;
        ye = (y0 < y1) ? y1 : y0;
        if (op == 1) begin
            xs = x0; xe = x0; ys = y0; ye = y0;
        end
        if (op == 3) begin
            xs = 0; ys = 0; xe = FB_WIDTH - 1; ye = FB_HEIGHT - 1;
        end
        for (int y = ys; y <= ye; y++) begin
            for (int x = xs; x <= xe; x++) begin
                p.we   = (x < FB_WIDTH) && (y < FB_HEIGHT);
                p.addr = y * FB_WIDTH + x;
                p.data = color;
                exp_q.push_back(p);
            end
        end
    endtask

    // Drive one command and return just after the edge that accepted it,
    // with cmd_valid dropped and cmd_* scrambled.
    task automatic applyStimulus(input int op, input int x0, input int y0,
                                 input int x1, input int y1, input int color,
                                 output bit ok);
        @(negedge clk);
        cmd_op    = 2'(op);
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_x1    = 8'(x1);
        cmd_y1    = 8'(y1);
        cmd_color = 3'(color);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_x0    = 8'($urandom);
        cmd_y0    = 8'($urandom);
        cmd_x1    = 8'($urandom);
        cmd_y1    = 8'($urandom);
        cmd_color = 3'($urandom);
    endtask

    task automatic test_reset();
        #2 rst_async = 1'b1;
        #1;
        checks++;
        if (fb_we !== 1'b0 || fb_waddr !== 16'd0 || fb_wdata !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: we=%0b addr=%0d data=%0d, want 0 0 0", fb_we, fb_waddr, fb_wdata);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: ready=%0b busy=%0b, want 1 0", cmd_ready, busy);
        end
        @(negedge clk);
        rst_async = 1'b0;
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: we=%0b ready=%0b, want 0 1", fb_we, cmd_ready);
        end
    endtask

    task automatic test_commands();
        cmd_t cmds[$];
        cmd_t c;
        bit   ok;
        cmds.push_back('{op: 1, x0: 5,   y0: 7, x1: 99,  y1: 99, color: 5});
        cmds.push_back('{op: 2, x0: 2,   y0: 1, x1: 0,   y1: 0,  color: 2});
        cmds.push_back('{op: 0, x0: 3,   y0: 3, x1: 9,   y1: 9,  color: 6});
        cmds.push_back('{op: 2, x0: 212, y0: 0, x1: 215, y1: 0,  color: 4});
        cmds.push_back('{op: 1, x0: 213, y0: 159, x1: 0, y1: 0,  color: 1});
        cmds.push_back('{op: 1, x0: 214, y0: 3, x1: 0,   y1: 0,  color: 3});
        for (int n = 0; n < 24; n++) begin
            c.op    = $urandom_range(0, 2);
            c.x0    = $urandom_range(0, 255);
            c.y0    = $urandom_range(0, 255);
            c.x1    = $urandom_range((c.x0 > 15) ? c.x0 - 15 : 0, (c.x0 < 240) ? c.x0 + 15 : 255);
            c.y1    = $urandom_range((c.y0 > 15) ? c.y0 - 15 : 0, (c.y0 < 240) ? c.y0 + 15 : 255);
            c.color = $urandom_range(0, 7);
            cmds.push_back(c);
        end
        foreach (cmds[n]) begin
            c = cmds[n];
            model_cmd(c.op, c.x0, c.y0, c.x1, c.y1, c.color);
            applyStimulus(c.op, c.x0, c.y0, c.x1, c.y1, c.color, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL cmd%0d_accept: cmd_ready=%0b, want 1 within 64 cycles", n, cmd_ready);
                continue;
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                checks++;
                if (fb_we !== exp_q[i].we || busy !== 1'b1 ||
                    (exp_q[i].we && (fb_waddr !== 16'(exp_q[i].addr) || fb_wdata !== 3'(exp_q[i].data)))) begin
                    errors++;
                    $display("[TB] FAIL cmd%0d_pix%0d: we=%0b addr=%0d data=%0d busy=%0b, want we=%0b addr=%0d data=%0d busy=1",
                             n, i, fb_we, fb_waddr, fb_wdata, busy, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
                end
            end
            @(negedge clk);
            checks++;
            if (fb_we !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL cmd%0d_done: we=%0b ready=%0b, want 0 1", n, fb_we, cmd_ready);
            end
        end
    endtask

    task automatic test_clear();
        bit ok;
        int cyc, bad, first_bad, bad_addr, bad_data;
        bit bad_we;
        model_cmd(3, 0, 0, 0, 0, 7);
        applyStimulus(3, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 7, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL clear_accept: cmd_ready=%0b, want 1", cmd_ready);
        end
        cyc = 0; bad = 0; first_bad = -1; bad_we = 0; bad_addr = 0; bad_data = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 40000) begin
            if (cyc >= exp_q.size() || fb_we !== exp_q[cyc].we ||
                fb_waddr !== 16'(exp_q[cyc].addr) || fb_wdata !== 3'(exp_q[cyc].data)) begin
                bad++;
                if (first_bad < 0) begin
                    first_bad = cyc; bad_we = fb_we; bad_addr = fb_waddr; bad_data = fb_wdata;
                end
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL clear_busy_cycles: got %0d, want %0d", cyc, exp_q.size());
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL clear_writes: %0d bad cycles, first at %0d we=%0b addr=%0d data=%0d, want we=1 addr=%0d data=7",
                     bad, first_bad, bad_we, bad_addr, bad_data, first_bad);
        end
        checks++;
        if (fb_we !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_done: we=%0b ready=%0b, want 0 1", fb_we, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        bit ok;
        c1 = $urandom_range(0, 7);
        c2 = $urandom_range(0, 7);
        @(negedge clk);
        cmd_op = 2'd1; cmd_x0 = 8'd0; cmd_y0 = 8'd0;
        cmd_x1 = 8'($urandom); cmd_y1 = 8'($urandom);
        cmd_color = 3'(c1); cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL b2b_accept: cmd_ready=%0b, want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_x0 = 8'd213; cmd_y0 = 8'd159; cmd_color = 3'(c2);
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || fb_waddr !== 16'd0 || fb_wdata !== 3'(c1) || cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first: we=%0b addr=%0d data=%0d ready=%0b, want 1 0 %0d 0",
                     fb_we, fb_waddr, fb_wdata, cmd_ready, c1);
        end
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_gap: we=%0b ready=%0b, want 0 1", fb_we, cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom); cmd_color = 3'($urandom);
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || fb_waddr !== 16'd34239 || fb_wdata !== 3'(c2)) begin
            errors++;
            $display("[TB] FAIL b2b_second: we=%0b addr=%0d data=%0d, want 1 34239 %0d", fb_we, fb_waddr, fb_wdata, c2);
        end
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_done: we=%0b ready=%0b, want 0 1", fb_we, cmd_ready);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int c;
        applyStimulus(3, 0, 0, 0, 0, 7, ok);
        repeat (100) @(negedge clk);
        checks++;
        if (!ok || fb_we !== 1'b1 || fb_waddr !== 16'd99) begin
            errors++;
            $display("[TB] FAIL abort_progress: ok=%0b we=%0b addr=%0d, want 1 1 99", ok, fb_we, fb_waddr);
        end
        #2 rst_async = 1'b1;
        #1;
        checks++;
        if (fb_we !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_async: we=%0b ready=%0b busy=%0b, want 0 1 0", fb_we, cmd_ready, busy);
        end
        @(negedge clk);
        rst_async = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_quiet: we=%0b ready=%0b, want 0 1", fb_we, cmd_ready);
        end
        c = $urandom_range(0, 7);
        applyStimulus(1, 1, 0, 50, 50, c, ok);
        @(negedge clk);
        checks++;
        if (!ok || fb_we !== 1'b1 || fb_waddr !== 16'd1 || fb_wdata !== 3'(c)) begin
            errors++;
            $display("[TB] FAIL abort_next_plot: ok=%0b we=%0b addr=%0d data=%0d, want 1 1 1 %0d",
                     ok, fb_we, fb_waddr, fb_wdata, c);
        end
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_next_done: we=%0b ready=%0b, want 0 1", fb_we, cmd_ready);
        end
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_commands();
        test_back_to_back();
        test_clear();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write-side engine for the 214x160, 3-bit-per-pixel framebuffer that the VGA scan-out block reads.
- Accepts drawing commands from the CPU over a valid/ready handshake: PLOT, FILL_RECT and CLEAR.
- Rasterises each command into one framebuffer write per clock on the framebuffer's write port.
- Uses incremental address generation (row base += FB_WIDTH), with no multiplier.

Parameters:
- FB_WIDTH, 214, pixels per line; linear address = y*FB_WIDTH + x
- FB_HEIGHT, 160, lines per frame
- ADDR_W, 16, framebuffer address width
- COLOR_W, 3, pixel width as {r,g,b}

Ports:
- clk  in  1  system clock, 50MHz
- rst_async  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; a command is accepted on a clk edge where cmd_valid&cmd_ready
- cmd_op  in  2  0=NOP, 1=PLOT, 2=FILL_RECT, 3=CLEAR
- cmd_x0  in  8  first x corner
- cmd_y0  in  8  first y corner
- cmd_x1  in  8  second x corner; ignored by PLOT and CLEAR
- cmd_y1  in  8  second y corner; ignored by PLOT and CLEAR
- cmd_color  in  COLOR_W  fill/plot colour
- busy  out  1  equals ~cmd_ready
- fb_we  out  1  write strobe
- fb_waddr  out  ADDR_W  write address
- fb_wdata  out  COLOR_W  write data

Behaviour:
- Reset:
  - rst_async is asynchronous and active-high; clock is clk.
  - On reset: state=IDLE, cmd_ready=1, busy=0, fb_we=0, fb_waddr=0, fb_wdata=0. All counters are cleared.
  - Reset during DRAW aborts the command immediately. Writes already issued remain; no further writes occur.
- Outputs: fb_we, fb_waddr and fb_wdata are registered.
- State machine:
  - IDLE -> DRAW on accept of PLOT, FILL_RECT or CLEAR.
  - An accepted NOP is consumed; the block stays in IDLE and issues no write.
  - DRAW -> IDLE on the clk edge after the last pixel is presented.
- Accept normalisation:
  - xs=min(x0,x1), xe=max(x0,x1); ys=min(y0,y1), ye=max(y0,y1).
  - PLOT: xe=xs=x0, ye=ys=y0.
  - CLEAR: xs=0, ys=0, xe=FB_WIDTH-1, ye=FB_HEIGHT-1.
  - Colour is latched at accept; later changes to cmd_* have no effect.
- Latency and throughput:
  - Command accepted at edge A. First write is presented in the cycle after A, with fb_we=1, addr=ys*FB_WIDTH+xs.
  - Exactly one pixel is presented per cycle, in raster order: x increments; at x==xe, x wraps to xs and y increments.
  - A command presents N=(xe-xs+1)*(ye-ys+1) write cycles. fb_we falls and cmd_ready rises together, N cycles after the first write.
  - Back-to-back commands: minimum one idle cycle (fb_we=0) between commands.
- Address arithmetic:
  - row_base is loaded with ys*FB_WIDTH at accept, via a shift-add constant multiply.
  - row_base += FB_WIDTH per row; fb_waddr = row_base + x.
  - All arithmetic is ADDR_W bits, unsigned. The maximum address, 34239, fits in 16 bits with no wrap.
- No backpressure: the framebuffer write port accepts every cycle.

Optional Feature:
- Macro: FB_WRITER_CLIP_EN
- Defined: at accept, any x > FB_WIDTH-1 is clamped to FB_WIDTH-1 and any y > FB_HEIGHT-1 is clamped to FB_HEIGHT-1, before normalisation. Every iterated pixel is written.
- Undefined: coordinates are used unclamped.
  - Iteration and cycle count are unchanged.
  - Pixels with x>=FB_WIDTH or y>=FB_HEIGHT are presented with fb_we=0 (suppressed), so no off-screen or aliased writes occur.

Decomposition:
- Shared package fb_pkg, also to be used by the VGA scan-out block:
  - FB_WIDTH, FB_HEIGHT, FB_PIXELS (34240), ADDR_W, COLOR_W
  - enum fb_op_t {FB_NOP, FB_PLOT, FB_FILL_RECT, FB_CLEAR}
  - typedef fb_color_t
- One sub-module, fb_raster_cnt: holds the x/y counters, the row_base accumulator and last-pixel detect.
- fb_writer keeps the handshake, state machine, normalisation and output registers.

Test Plan:
- PLOT (5,7), colour 3'b101 -> exactly one write of addr 1503, data 5, in the cycle after accept. cmd_ready is low for 1 cycle.
- FILL_RECT (2,1)-(0,0), swapped corners, colour 3'b010 -> 6 consecutive writes at addrs 0,1,2,214,215,216, data 2. Then cmd_ready=1.
- CLEAR, colour 3'b111 -> 34240 consecutive writes at addrs 0..34239, all data 7. busy is high for exactly 34240 cycles.
- cmd_valid held high with two PLOTs, (0,0) then (213,159) -> writes at addr 0 and addr 34239, separated by exactly one fb_we=0 cycle. The cmd_* change during DRAW is ignored.
- Reset during a CLEAR after 100 writes -> fb_we=0 and cmd_ready=1 asynchronously. The next PLOT (1,0) writes addr 1 correctly.
- FILL_RECT (212,0)-(215,0):
  - With FB_WRITER_CLIP_EN -> 2 writes, at 212 and 213.
  - Without it -> 4 cycles, of which only 212 and 213 have fb_we=1.
